// File: rtl/relu.sv
// Registered saturating ReLU for signed Q(INT_BITS.FRAC_BITS) fixed-point data.
// Negative inputs become zero; positives above MAX_POS clamp to MAX_POS and
// raise overflow. One-cycle latency, one result per enabled clock.
module relu #(
  parameter int unsigned INT_BITS  = 16,
  parameter int unsigned FRAC_BITS = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                enable,
  input  logic [INT_BITS+FRAC_BITS-1:0]       data_in,
  output logic [INT_BITS+FRAC_BITS-1:0]       data_out,
  output logic                                valid,
  output logic                                overflow
);

  localparam int unsigned DATA_WIDTH = INT_BITS + FRAC_BITS;

  // Largest integer value with zero fraction: 0 sign, all-ones integer, zero fraction.
  localparam logic [DATA_WIDTH-1:0] MAX_POS =
    {1'b0, {(INT_BITS-1){1'b1}}, {FRAC_BITS{1'b0}}};
  localparam logic [DATA_WIDTH-1:0] ZERO = '0;

  logic                  is_neg;
  logic                  is_over;
  logic [DATA_WIDTH-1:0] sat_value;

  // Classify the operand (signed, full width) and pick the saturated result.
  always_comb begin
    is_neg    = data_in[DATA_WIDTH-1];
    is_over   = 1'b0;
    sat_value = data_in;
    if (is_neg) begin
      sat_value = ZERO;
    end else if ($signed(data_in) > $signed(MAX_POS)) begin
      is_over   = 1'b1;
      sat_value = MAX_POS;
    end
  end

  // Output registers; data holds on disabled edges, strobes clear.
  // The port named rst_n is an active-high asynchronous reset.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      data_out <= ZERO;
      valid    <= 1'b0;
      overflow <= 1'b0;
    end else if (enable) begin
      data_out <= sat_value;
      valid    <= 1'b1;
      overflow <= is_over;
    end else begin
      valid    <= 1'b0;
      overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_relu.sv
// Scoreboard bench for relu: the driver pushes hand-computed expectations,
// a monitor compares every cycle just after the rising edge.
module tb_relu;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic [31:0] data_in;
  logic [31:0] data_out;
  logic        valid;
  logic        overflow;

  int unsigned pass_cnt;
  int unsigned total_cnt;

  logic [32:0] exp_q[$];
  logic [31:0] last_data;

  relu dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .data_in  (data_in),
    .data_out (data_out),
    .valid    (valid),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Apply one input at the falling edge; enabled inputs queue their expectation.
  task automatic drive(input logic [31:0] d, input logic en,
                       input logic [31:0] exp_d, input logic exp_o);
    @(negedge clk);
    data_in = d;
    enable  = en;
    if (en) exp_q.push_back({exp_o, exp_d});
  endtask

  // Monitor: compare outputs 1 time unit after every rising edge.
  initial begin
    logic en_s;
    logic rs_s;
    logic [32:0] e;
    last_data = 32'h0;
    forever begin
      @(posedge clk);
      en_s = enable;
      rs_s = rst_n;
      #1;
      if (rs_s || rst_n) begin
        last_data = 32'h0;
      end else if (en_s) begin
        check("valid_on", {31'h0, valid}, 32'h1);
        if (exp_q.size() == 0) begin
          check("unexpected_result", 32'h1, 32'h0);
        end else begin
          e = exp_q.pop_front();
          check("data_out", data_out, e[31:0]);
          check("overflow", {31'h0, overflow}, {31'h0, e[32]});
          last_data = e[31:0];
        end
      end else begin
        check("valid_off", {31'h0, valid}, 32'h0);
        check("overflow_off", {31'h0, overflow}, 32'h0);
        check("data_hold", data_out, last_data);
      end
    end
  end

  localparam int N = 11;
  logic [31:0] vin  [N] = '{32'h0000FFFF, 32'h00028000, 32'h00000001, 32'h00018001,
                            32'h00008000, 32'h00000000, 32'hFFFF0000, 32'h80000000,
                            32'h7FFF0000, 32'h7FFF8000, 32'h7FFFFFFF};
  logic [31:0] vout [N] = '{32'h0000FFFF, 32'h00028000, 32'h00000001, 32'h00018001,
                            32'h00008000, 32'h00000000, 32'h00000000, 32'h00000000,
                            32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000};
  logic        vovf [N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                            1'b0, 1'b1, 1'b1};

  initial begin
    int guard;
    pass_cnt  = 0;
    total_cnt = 0;
    rst_n     = 1'b1;
    enable    = 1'b0;
    data_in   = 32'h0;
    #1;
    check("reset_data", data_out, 32'h0);
    check("reset_valid", {31'h0, valid}, 32'h0);
    check("reset_ovf", {31'h0, overflow}, 32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;

    // Back-to-back stream covering in-range, zero, negative and boundary values.
    for (int i = 0; i < N; i++) drive(vin[i], 1'b1, vout[i], vovf[i]);
    drive(32'h0, 1'b0, 32'h0, 1'b0);

    // Enable low: data holds while data_in changes; strobes clear.
    drive(32'h00028000, 1'b1, 32'h00028000, 1'b0);
    drive(32'h12345678, 1'b0, 32'h0, 1'b0);
    drive(32'hFFFFFFFF, 1'b0, 32'h0, 1'b0);
    drive(32'h7FFFFFFF, 1'b1, 32'h7FFF0000, 1'b1);
    drive(32'h00000003, 1'b0, 32'h0, 1'b0);
    drive(32'h00000004, 1'b0, 32'h0, 1'b0);

    // Asynchronous reset while valid is high.
    drive(32'h00010000, 1'b1, 32'h00010000, 1'b0);
    @(posedge clk);
    #3;
    check("pre_reset_valid", {31'h0, valid}, 32'h1);
    rst_n = 1'b1;
    #1;
    check("async_rst_data", data_out, 32'h0);
    check("async_rst_valid", {31'h0, valid}, 32'h0);
    check("async_rst_ovf", {31'h0, overflow}, 32'h0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;

    // First result after release.
    drive(32'h00000005, 1'b1, 32'h00000005, 1'b0);
    drive(32'h7FFF0001, 1'b1, 32'h7FFF0000, 1'b1);
    drive(32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);

    guard = 0;
    while (exp_q.size() != 0 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 32'h0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
